// File: rtl/mem_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_master_pkg
// Description : Shared types and constants for the 16-bit memory request
//               master: controller state encoding, byte-enable patterns and
//               the memory word type.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_master_pkg;

    typedef logic [15:0] mem_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/byte_lane_steer.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_steer
// Description : Combinational lane steering for 16-bit memory accesses.
//               Write side: byte enables and replicated store data from the
//               access size and address bit 0.
//               Read side: selects and zero-extends the addressed byte lane.
// Ports       : i_byte/i_lane/i_wdata       -> o_be/o_wdata   (write path)
//               i_rd_byte/i_rd_lane/i_rdata -> o_rdata        (read path)
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_steer
    import mem_master_pkg::*;
(
    input  logic       i_byte,
    input  logic       i_lane,
    input  mem_word_t  i_wdata,
    output logic [1:0] o_be,
    output mem_word_t  o_wdata,
    input  logic       i_rd_byte,
    input  logic       i_rd_lane,
    input  mem_word_t  i_rdata,
    output mem_word_t  o_rdata
);

    // A byte store drives the same byte on both lanes; the enables decide
    // which lane the memory actually commits.
    always_comb begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        if (i_byte) begin
            o_be    = i_lane ? BE_HI : BE_LO;
            o_wdata = {i_wdata[7:0], i_wdata[7:0]};
        end
    end

    always_comb begin
        o_rdata = i_rdata;
        if (i_rd_byte) begin
            o_rdata = i_rd_lane ? {8'h00, i_rdata[15:8]} : {8'h00, i_rdata[7:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_request_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_request_master
// Description : Initiator-side controller for the 16-bit memory handshake.
//               Accepts one CPU load/store at a time, presents a held,
//               lane-steered request to memory until mem_resp, then returns
//               aligned read data with a one-cycle cpu_done pulse.
// Ports       : clk, rst (sync, active-high)
//               cpu_req_* / cpu_addr / cpu_wdata  : CPU request side
//               cpu_done / cpu_rdata / cpu_err    : CPU completion side
//               mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata,
//               mem_resp/mem_rdata                : memory port
// Config      : MEM_TIMEOUT_EN - abort BUSY after TIMEOUT_CYCLES cycles
//               without mem_resp and flag cpu_err with cpu_done.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_request_master
    import mem_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req_valid,
    output logic       cpu_req_ready,
    input  logic       cpu_req_write,
    input  logic       cpu_req_byte,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic       cpu_done,
    output logic [15:0] cpu_rdata,
    output logic       cpu_err,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_byte_enable,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic       mem_resp,
    input  logic [15:0] mem_rdata
);

    localparam logic [1:0] c_S_IDLE = IDLE;
    localparam logic [1:0] c_S_BUSY = BUSY;
    localparam logic [1:0] c_S_DONE = DONE;

    logic [1:0] r_state;
    logic       r_ready;
    logic       r_done;
    logic       r_err;
    logic       r_read;
    logic       r_write;
    logic [1:0] r_be;
    mem_word_t  r_addr;
    mem_word_t  r_wdata;
    mem_word_t  r_rdata;
    logic       r_lane;
    logic       r_byte;

    logic       w_accept;
    logic       w_timeout;
    logic [1:0] w_be;
    mem_word_t  w_wdata;
    mem_word_t  w_rd_aligned;

    // r_ready is high exactly in IDLE, so this is the only accept condition.
    assign w_accept = r_ready & cpu_req_valid;

    byte_lane_steer u_steer (
        .i_byte    (cpu_req_byte),
        .i_lane    (cpu_addr[0]),
        .i_wdata   (cpu_wdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .i_rd_byte (r_byte),
        .i_rd_lane (r_lane),
        .i_rdata   (mem_rdata),
        .o_rdata   (w_rd_aligned)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == c_S_BUSY) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // r_cnt counts BUSY cycles already elapsed; the edge ending the
    // TIMEOUT_CYCLES-th BUSY cycle is the abort edge.
    assign w_timeout = (r_state == c_S_BUSY) && (r_cnt == c_CNT_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_be    <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_lane  <= 1'b0;
            r_byte  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_S_BUSY;
                        r_ready <= 1'b0;
                        r_read  <= ~cpu_req_write;
                        r_write <= cpu_req_write;
                        r_be    <= w_be;
                        r_addr  <= {cpu_addr[15:1], 1'b0};
                        r_wdata <= w_wdata;
                        r_lane  <= cpu_addr[0];
                        r_byte  <= cpu_req_byte;
                    end
                end
                c_S_BUSY: begin
                    // mem_resp has priority over a coincident timeout.
                    if (mem_resp) begin
                        if (r_read) begin
                            r_rdata <= w_rd_aligned;
                        end
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_S_DONE;
                    end else if (w_timeout) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_ready <= 1'b1;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_req_ready   = r_ready;
    assign cpu_done        = r_done;
    assign cpu_err         = r_err;
    assign cpu_rdata       = r_rdata;
    assign mem_read        = r_read;
    assign mem_write       = r_write;
    assign mem_byte_enable = r_be;
    assign mem_address     = r_addr;
    assign mem_wdata       = r_wdata;

endmodule
`default_nettype wire

// File: doc/mem_request_master.md
Name: mem_request_master

Overview:
Initiator-side controller for the 16-bit memory handshake (read/write/byte_enable/address/wdata → resp/rdata).
- Accepts one CPU-side load/store request at a time.
- Converts byte accesses into lane-steered byte enables.
- Holds the memory request stable until resp, then returns aligned read data with a one-cycle done pulse.
- Sits between the datapath control and the memory port.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles waited in BUSY for mem_resp; used only when MEM_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cpu_req_valid  input  1  request present; held by CPU until accepted
cpu_req_ready  output  1  high only in IDLE; accept = valid & ready at clk edge
cpu_req_write  input  1  1 = store, 0 = load
cpu_req_byte  input  1  1 = byte access, 0 = word access
cpu_addr  input  16  byte address
cpu_wdata  input  16  store data; byte store uses [7:0]
cpu_done  output  1  one-cycle pulse: access complete
cpu_rdata  output  16  load result; valid from cpu_done, held until next accept
cpu_err  output  1  pulses with cpu_done on timeout abort; constant 0 without MEM_TIMEOUT_EN
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_byte_enable  output  2  lane enables: [1] = high byte, [0] = low byte
mem_address  output  16  word-aligned address; bit 0 always 0
mem_wdata  output  16  lane-steered write data
mem_resp  input  1  memory completion; may be a single-cycle pulse
mem_rdata  input  16  read data; valid in the mem_resp cycle

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; cpu_req_ready = 1; all other outputs = 0, including cpu_rdata = 16'h0000.
- States and transitions:
  - IDLE → BUSY on accept.
  - BUSY → DONE on mem_resp.
  - DONE → IDLE unconditionally.
- On accept, at the same edge, latch:
  - mem_address = {cpu_addr[15:1], 1'b0}.
  - Exactly one of mem_read / mem_write = 1, per cpu_req_write.
  - Byte enables:
    - word: be = 2'b11, wdata = cpu_wdata, cpu_addr[0] ignored.
    - byte, addr[0] = 0: be = 2'b01.
    - byte, addr[0] = 1: be = 2'b10.
    - byte wdata = {cpu_wdata[7:0], cpu_wdata[7:0]} in both byte cases.
  - Latch the lane select (addr[0]) and size for read alignment.
- BUSY:
  - mem_read/mem_write, address, be and wdata held constant every cycle.
  - On the mem_resp edge:
    - Load cpu_rdata: word = mem_rdata; byte = zero-extended selected lane ({8'h00, mem_rdata[7:0]} or {8'h00, mem_rdata[15:8]}).
    - Clear mem_read/mem_write at the same edge.
- DONE:
  - cpu_done = 1 for exactly this cycle.
  - mem_read/mem_write = 0 so the memory can return to idle.
  - cpu_req_ready = 0.
- Latency:
  - Memory sees the request the cycle after accept.
  - cpu_done occurs the cycle after the mem_resp edge.
  - Minimum accept-to-done is 2 cycles.
  - Back-to-back requests are separated by at least one cycle with read/write low.
- Store completion leaves cpu_rdata unchanged.
- Boundary conditions:
  - mem_resp seen in IDLE or DONE: ignored.
  - cpu_req_valid while not ready: ignored, no queuing.
  - Address 16'hFFFF byte access: mem_address = 16'hFFFE, be = 2'b10 (no wrap).
  - rst in any state: next edge forces IDLE and drops mem_read/mem_write; any in-flight access is abandoned with no cpu_done.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - Cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears on accept and increments in BUSY.
  - When it reaches TIMEOUT_CYCLES without mem_resp: BUSY → DONE, mem_read/mem_write dropped, cpu_rdata unchanged, cpu_err = 1 alongside cpu_done.
  - mem_resp and timeout in the same cycle: mem_resp wins, cpu_err = 0.
- Undefined: no counter; BUSY waits indefinitely; cpu_err tied 0.

Decomposition:
- Package mem_master_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - Byte-enable constants BE_WORD = 2'b11, BE_LO = 2'b01, BE_HI = 2'b10.
  - typedef mem_word_t (logic [15:0]).
- Sub-module byte_lane_steer: combinational be/wdata generation and read-lane extraction, shared by the write and read paths.

Test Plan:
- Word load at 16'h1234, memory returns 16'hBEEF after 5 cycles → mem_address = 16'h1234, be = 11, mem_read held 5 cycles; cpu_rdata = 16'hBEEF with a single cpu_done pulse.
- Byte store of 8'hA5 at 16'h2001 → be = 10, mem_wdata = 16'hA5A5, mem_address = 16'h2000; mem_write drops at the resp edge.
- Byte load at 16'h2000, then at 16'h2001, mem_rdata = 16'h12AB → cpu_rdata = 16'h00AB, then 16'h0012; mem_read low for at least 1 cycle between requests.
- cpu_req_valid held high continuously across 3 word loads → exactly 3 accepts; no acceptance while BUSY/DONE; a spurious mem_resp in IDLE causes no cpu_done.
- rst asserted mid-BUSY → mem_read = 0 and cpu_req_ready = 1 after that edge; no cpu_done.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no mem_resp → cpu_done with cpu_err = 1 exactly 8 BUSY cycles after accept; cpu_rdata unchanged.
